sseg_scan_driver: RTL and testbench

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

---
 rtl/sseg_scan_driver.sv | 184 ++++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scan driver with tear-free shadow/active update at frame wrap.
// Optional per-digit blinking is built when SSEG_BLINK_EN is defined.
module sseg_scan_driver #(
  parameter int DIGITS    = 8,
  parameter int DIV       = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
`ifdef SSEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  input  logic                  load,
  input  logic                  lzs,
  output logic [6:0]            sseg,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  if (DIGITS < 1 || DIGITS > 16 || DIV < 1 || BLINK_DIV < 1) begin : g_param_check
    $error("sseg_scan_driver: illegal parameter value");
  end

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                digit_tick;
  logic                frame_wrap;

  logic [4*DIGITS-1:0] val_sh;
  logic [4*DIGITS-1:0] val_act;
  logic [DIGITS-1:0]   mask_sh;
  logic [DIGITS-1:0]   mask_act;

  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                cur_supp;
  logic                lead_zero;

  assign digit_tick = (cnt == CNT_LAST);
  assign frame_wrap = digit_tick && (idx == IDX_LAST);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and ordering between always_ff blocks cannot matter.
  always_ff @(posedge clk or posedge rst) begin : p_scan
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (digit_tick) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Active data changes only at frame wrap so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge rst) begin : p_data
    if (rst) begin
      val_sh   <= '0;
      val_act  <= '0;
      mask_sh  <= '1;
      mask_act <= '1;
      pending  <= 1'b0;
    end else if (load && frame_wrap) begin
      val_sh   <= value;
      val_act  <= value;
      mask_sh  <= blank_mask;
      mask_act <= blank_mask;
      pending  <= 1'b0;
    end else if (load) begin
      val_sh   <= value;
      mask_sh  <= blank_mask;
      pending  <= 1'b1;
    end else if (frame_wrap) begin
      val_act  <= val_sh;
      mask_act <= mask_sh;
      pending  <= 1'b0;
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [DIGITS-1:0] blink_sh;
  logic [DIGITS-1:0] blink_act;
  logic [BLK_W-1:0]  blink_cnt;
  logic              blink_on;

  always_ff @(posedge clk or posedge rst) begin : p_blink
    if (rst) begin
      blink_sh  <= '0;
      blink_act <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      if (load && frame_wrap) begin
        blink_sh  <= blink;
        blink_act <= blink;
      end else if (load) begin
        blink_sh  <= blink;
      end else if (frame_wrap) begin
        blink_act <= blink_sh;
      end
      if (frame_wrap) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero && (val_act[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        cur_nib   = val_act[4*i +: 4];
`ifdef SSEG_BLINK_EN
        cur_blank = mask_act[i] || (blink_act[i] && !blink_on);
`else
        cur_blank = mask_act[i];
`endif
        cur_supp  = lzs && lead_zero && (i != 0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_drive
    if (rst) begin
      an   <= '1;
      sseg <= SEG_BLANK;
    end else begin
      an   <= ~(DIGITS'(1) << idx);
      sseg <= (cur_blank || cur_supp) ? SEG_BLANK : hex_to_seg(cur_nib);
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver (DIGITS=4, DIV=2): stimulus queues expected
// digit drives per frame; a monitor pops them whenever the digit enable changes.
module tb_sseg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '1;
  logic        load = 1'b0;
  logic        lzs = 1'b0;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;
`ifdef SSEG_BLINK_EN
  logic [3:0]  blink = '0;
`endif

  sseg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .blank_mask (blank_mask),
`ifdef SSEG_BLINK_EN
    .blink      (blink),
`endif
    .load       (load),
    .lzs        (lzs),
    .sseg       (sseg),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
  } disp_t;

  disp_t exp_q[$];
  int    checks = 0;
  int    passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    exp_q.push_back(disp_t'{an: 4'hE, sseg: s0});
    exp_q.push_back(disp_t'{an: 4'hD, sseg: s1});
    exp_q.push_back(disp_t'{an: 4'hB, sseg: s2});
    exp_q.push_back(disp_t'{an: 4'h7, sseg: s3});
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 4 * FRAME);
    check(name, 32'(frame_done), 32'd1);
  endtask

  task automatic load_at_negedge(input logic [15:0] v, input logic [3:0] m);
    value      = v;
    blank_mask = m;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  // Monitor: compares every new digit drive with the scoreboard head.
  logic [3:0] prev_an = 4'hF;
  logic       prev_fd = 1'b0;
  int         hold    = 0;
  int         since   = 0;
  bit         armed   = 1'b0;
  disp_t      got;
  disp_t      want;

  initial begin
    forever begin
      @(negedge clk);
      since++;
      if (an !== prev_an) begin
        if (prev_an !== 4'hF && an !== 4'hF) check("hold", 32'(hold), 32'(DIV));
        if (an !== 4'hF) begin
          got = disp_t'{an: an, sseg: sseg};
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL digit at %0t: got an=%h sseg=%h with no expected entry", $time, an, sseg);
          end else begin
            want = exp_q.pop_front();
            check("digit", 32'(got), 32'(want));
          end
        end
        hold    = 1;
        prev_an = an;
      end else begin
        hold++;
      end
      if (rst) armed = 1'b0;
      if (frame_done) begin
        check("fd_width", 32'(prev_fd), 32'd0);
        if (armed) check("frame_period", 32'(since), 32'(FRAME));
        armed = 1'b1;
        since = 0;
      end
      prev_fd = frame_done;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'h7F);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    rst = 1'b0;

    wait_fd("fd_first");
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Mid-frame load stays pending until the wrap.
    repeat (3) @(negedge clk);
    load_at_negedge(16'h12AF, 4'h0);
    check("pending_set", 32'(pending), 32'd1);
    wait_fd("fd_12af");
    check("pending_clr", 32'(pending), 32'd0);
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79);

    // Leading-zero suppression, live lzs.
    repeat (2) @(negedge clk);
    load_at_negedge(16'h0005, 4'h0);
    wait_fd("fd_0005");
    lzs = 1'b1;
    push_frame(7'h12, 7'h7F, 7'h7F, 7'h7F);
    wait_fd("fd_lzs");
    lzs = 1'b0;
    push_frame(7'h12, 7'h40, 7'h40, 7'h40);

    // Load coincident with the wrap goes straight to active.
    repeat (FRAME - 1) @(negedge clk);
    load_at_negedge(16'h8888, 4'h0);
    check("wrap_fd", 32'(frame_done), 32'd1);
    check("wrap_pending", 32'(pending), 32'd0);
    push_frame(7'h00, 7'h00, 7'h00, 7'h00);

    // Two loads in one frame: last one wins.
    repeat (2) @(negedge clk);
    value = 16'h1111; blank_mask = 4'h0; load = 1'b1;
    @(negedge clk);
    value = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    check("pending_multi", 32'(pending), 32'd1);
    wait_fd("fd_2222");
    check("pending_multi_clr", 32'(pending), 32'd0);
    push_frame(7'h24, 7'h24, 7'h24, 7'h24);

    // Asynchronous reset with pending shadow data.
    repeat (2) @(negedge clk);
    load_at_negedge(16'h3333, 4'h0);
    check("pending_pre_rst", 32'(pending), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_an", 32'(an), 32'hF);
    check("arst_sseg", 32'(sseg), 32'h7F);
    exp_q.delete();
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_fd("fd_after_rst");
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Blank mask on digit 1.
    repeat (2) @(negedge clk);
    load_at_negedge(16'h4321, 4'b0010);
    wait_fd("fd_4321");
    push_frame(7'h79, 7'h7F, 7'h30, 7'h19);

    repeat (2) @(negedge clk);
    load_at_negedge(16'hDCB9, 4'h0);
    wait_fd("fd_dcb9");
    push_frame(7'h10, 7'h03, 7'h46, 7'h21);
    wait_fd("fd_dcb9_hold");
    push_frame(7'h10, 7'h03, 7'h46, 7'h21);

    repeat (FRAME) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
